tx_serial_8n1: RTL and testbench

TX_SERIAL_8N1 -- requirements
Module: tx_serial_8N1

---
 rtl/tx_serial_8n1.sv | 165 ++++++++++++++++
 tb/tb_tx_serial_8n1.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_serial_8n1.sv
// 8N1 serial transmitter fed by a FIFO_DEPTH-byte queue; start bit falls one edge after a write to an idle block.
// Writes while cheio are dropped silently; queued frames go out every 10*CLKS_PER_BIT+2 cycles.
module sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         wr_vld,
   input  logic [W-1:0] wr_dat,
   input  logic         rd_rdy,
   output logic [W-1:0] rd_dat,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          wr_en;
   logic          rd_en;

   assign full   = (count == (AW+1)'(DEPTH));
   assign empty  = (count == '0);
   assign wr_en  = wr_vld && !full;
   assign rd_en  = rd_rdy && !empty;
   assign rd_dat = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (wr_en && reset) begin
         mem[wr_ptr] <= wr_dat;
      end
   end

   // A write while full is dropped even when the same cycle pops.
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module tx_serial_8n1 #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       partida,
   input  logic [7:0] dados_ascii,
   output logic       saida_serial,
   output logic       pronto,
   output logic       ocupado,
   output logic       cheio,
   output logic       vazio,
   output logic [3:0] db_estado,
   output logic       db_tick
);
   localparam int CW = $clog2(CLKS_PER_BIT);

   typedef enum logic [3:0] {
      INICIAL = 4'd0,
      PARTIDA = 4'd1,
      DADOS   = 4'd2,
      PARADA  = 4'd3,
      FIM     = 4'd4
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [7:0]    shreg;
   logic [7:0]    shreg_nxt;
   logic [7:0]    fifo_dat;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [2:0]    bit_cnt;
   logic [2:0]    bit_nxt;
   logic          pop;
   logic          tick;
   logic          line_nxt;

   sync_fifo #(
      .W     (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock  (clock),
      .reset  (reset),
      .wr_vld (partida),
      .wr_dat (dados_ascii),
      .rd_rdy (pop),
      .rd_dat (fifo_dat),
      .full   (cheio),
      .empty  (vazio)
   );

   assign tick      = (cnt == CW'(CLKS_PER_BIT - 1));
   assign db_tick   = tick;
   assign db_estado = state;
   assign ocupado   = (state != INICIAL) || !vazio;

   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      bit_nxt   = bit_cnt;
      cnt_nxt   = tick ? '0 : cnt + 1'b1;
      pop       = 1'b0;
      case (state)
         INICIAL: begin
            if (!vazio) begin
               pop       = 1'b1;
               shreg_nxt = fifo_dat;
               cnt_nxt   = '0;
               bit_nxt   = '0;
               state_nxt = PARTIDA;
            end
         end
         PARTIDA: if (tick) state_nxt = DADOS;
         DADOS: begin
            if (tick) begin
               shreg_nxt = {1'b0, shreg[7:1]};
               bit_nxt   = bit_cnt + 1'b1;
               if (bit_cnt == 3'd7) state_nxt = PARADA;
            end
         end
         PARADA:  if (tick) state_nxt = FIM;
         FIM:     state_nxt = INICIAL;
         default: state_nxt = INICIAL;
      endcase

      // Line and pronto are registered from the next-state decode so they never glitch.
      line_nxt = 1'b1;
      if (state_nxt == PARTIDA)    line_nxt = 1'b0;
      else if (state_nxt == DADOS) line_nxt = shreg_nxt[0];
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state        <= INICIAL;
         shreg        <= '0;
         cnt          <= '0;
         bit_cnt      <= '0;
         saida_serial <= 1'b1;
         pronto       <= 1'b0;
      end else begin
         state        <= state_nxt;
         shreg        <= shreg_nxt;
         cnt          <= cnt_nxt;
         bit_cnt      <= bit_nxt;
         saida_serial <= line_nxt;
         pronto       <= (state_nxt == FIM);
      end
   end
endmodule

// File: tb/tb_tx_serial_8n1.sv
// Scoreboarded bench for tx_serial_8n1 at CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Stimulus queues expected bytes and start cycles; a line monitor decodes frames and compares.
module tb_tx_serial_8n1;
   logic       clock;
   logic       reset;
   logic       partida;
   logic [7:0] dados_ascii;
   logic       saida_serial;
   logic       pronto;
   logic       ocupado;
   logic       cheio;
   logic       vazio;
   logic [3:0] db_estado;
   logic       db_tick;

   typedef struct {
      logic [7:0] dat;
      int         fall;
   } exp_t;

   exp_t exp_q[$];
   int   checks     = 0;
   int   errors     = 0;
   int   cyc        = 0;
   int   pronto_cnt = 0;

   tx_serial_8n1 #(
      .CLKS_PER_BIT (4),
      .FIFO_DEPTH   (4)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .partida      (partida),
      .dados_ascii  (dados_ascii),
      .saida_serial (saida_serial),
      .pronto       (pronto),
      .ocupado      (ocupado),
      .cheio        (cheio),
      .vazio        (vazio),
      .db_estado    (db_estado),
      .db_tick      (db_tick)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;
   always @(negedge clock) if (pronto) pronto_cnt <= pronto_cnt + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic write_byte(input logic [7:0] d, output int e);
      partida     = 1'b1;
      dados_ascii = d;
      @(posedge clock);
      #3;
      e       = cyc;
      partida = 1'b0;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) begin
         @(posedge clock);
         #3;
      end
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while ((ocupado || exp_q.size() != 0) && n < budget) begin
         @(posedge clock);
         #3;
         n++;
      end
      chk(name, 64'({ocupado, vazio, exp_q.size() == 0}), 64'(3'b011));
   endtask

   // Frame monitor: 41 samples from the start-bit fall up to and including the pronto cycle.
   initial begin : monitor
      logic        prev_line;
      logic [40:0] got_line;
      logic [40:0] got_pr;
      logic [40:0] exp_line;
      logic [40:0] exp_pr;
      logic [7:0]  got_byte;
      bit          aborted;
      int          fall;
      exp_t        it;
      prev_line = 1'b1;
      forever begin
         @(negedge clock);
         if (reset && prev_line && !saida_serial) begin
            fall        = cyc;
            got_line    = '0;
            got_pr      = '0;
            got_line[0] = saida_serial;
            got_pr[0]   = pronto;
            aborted     = 1'b0;
            for (int i = 1; i <= 40; i++) begin
               @(negedge clock);
               if (!reset) begin
                  aborted = 1'b1;
                  break;
               end
               got_line[i] = saida_serial;
               got_pr[i]   = pronto;
            end
            if (!aborted) begin
               for (int k = 0; k < 8; k++) got_byte[k] = got_line[6 + 4*k];
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame: got byte %0h, expected no frame", got_byte);
               end else begin
                  it = exp_q.pop_front();
                  for (int i = 0; i <= 40; i++) begin
                     if (i < 4)       exp_line[i] = 1'b0;
                     else if (i < 36) exp_line[i] = it.dat[(i - 4) / 4];
                     else             exp_line[i] = 1'b1;
                  end
                  exp_pr     = '0;
                  exp_pr[40] = 1'b1;
                  chk($sformatf("frame_line_%0h", it.dat), 64'(got_line), 64'(exp_line));
                  chk($sformatf("frame_pronto_%0h", it.dat), 64'(got_pr), 64'(exp_pr));
                  if (it.fall >= 0)
                     chk($sformatf("frame_start_cycle_%0h", it.dat), 64'(fall), 64'(it.fall));
               end
            end
         end else if (reset && pronto) begin
            chk("spurious_pronto", 64'(pronto), 64'(1'b0));
         end
         prev_line = saida_serial;
      end
   end

   initial begin : stim
      int         e;
      int         e0;
      int         pr0;
      logic [4:0] burst_cheio;
      logic [7:0] d;

      // Reset with partida held high: the write must be discarded.
      reset       = 1'b0;
      partida     = 1'b1;
      dados_ascii = 8'hEE;
      repeat (3) @(posedge clock);
      #3;
      chk("reset_hold", 64'({saida_serial, pronto, ocupado, cheio, vazio, db_estado}), 64'(9'b1_0001_0000));
      partida = 1'b0;
      reset   = 1'b1;
      @(posedge clock);
      #3;
      chk("reset_release", 64'({saida_serial, pronto, ocupado, cheio, vazio, db_estado}), 64'(9'b1_0001_0000));

      // Single byte 0x55.
      write_byte(8'h55, e);
      exp_q.push_back('{8'h55, e + 1});
      chk("single_queued", 64'({ocupado, vazio}), 64'(2'b10));
      wait_idle("single_idle", 200);

      // Latency and framing with 0xA3.
      repeat (3) begin @(posedge clock); #3; end
      write_byte(8'hA3, e);
      exp_q.push_back('{8'hA3, e + 1});
      wait_idle("a3_idle", 200);

      // Burst of five writes: head pops at once, four fill the FIFO.
      pr0         = pronto_cnt;
      burst_cheio = 5'b10000;
      e0          = 0;
      for (int i = 0; i < 5; i++) begin
         d = 8'(i + 1);
         write_byte(d, e);
         if (i == 0) e0 = e;
         exp_q.push_back('{d, e0 + 1 + 42*i});
         chk($sformatf("burst_cheio_%0d", i), 64'(cheio), 64'(burst_cheio[i]));
      end
      wait_idle("burst_idle", 400);
      chk("burst_pronto_count", 64'(pronto_cnt - pr0), 64'(5));

      // Overflow: 0xFF written while full is dropped.
      write_byte(8'h11, e0);
      exp_q.push_back('{8'h11, e0 + 1});
      write_byte(8'h22, e);
      exp_q.push_back('{8'h22, e0 + 43});
      write_byte(8'h33, e);
      exp_q.push_back('{8'h33, e0 + 85});
      write_byte(8'h44, e);
      exp_q.push_back('{8'h44, e0 + 127});
      write_byte(8'h66, e);
      exp_q.push_back('{8'h66, e0 + 169});
      chk("ovf_full", 64'(cheio), 64'(1'b1));
      write_byte(8'hFF, e);
      chk("ovf_still_full", 64'({cheio, ocupado}), 64'(2'b11));
      wait_idle("ovf_idle", 400);

      // Reset in the middle of the data bits, with a second byte queued.
      pr0 = pronto_cnt;
      write_byte(8'h3C, e);
      write_byte(8'h99, e);
      repeat (8) begin @(posedge clock); #3; end
      chk("pre_reset_state", 64'(db_estado), 64'(4'd2));
      reset = 1'b0;
      @(posedge clock);
      #3;
      chk("rst_mid_outputs", 64'({saida_serial, pronto, ocupado, cheio, vazio, db_estado}), 64'(9'b1_0001_0000));
      reset = 1'b1;
      repeat (60) begin @(posedge clock); #3; end
      chk("rst_mid_no_pronto", 64'(pronto_cnt - pr0), 64'(0));
      chk("rst_mid_idle", 64'({ocupado, vazio}), 64'(2'b01));
      write_byte(8'h0F, e);
      exp_q.push_back('{8'h0F, e + 1});
      wait_idle("rst_mid_0f_idle", 200);

      // Write/pop collision at count=2, then a dropped write while full in a popping cycle.
      write_byte(8'hA1, e0);
      exp_q.push_back('{8'hA1, e0 + 1});
      write_byte(8'hB2, e);
      exp_q.push_back('{8'hB2, e0 + 43});
      write_byte(8'hC3, e);
      exp_q.push_back('{8'hC3, e0 + 85});
      wait_until(e0 + 42);
      chk("coll_pre_state", 64'({db_estado, cheio, vazio}), 64'(6'b0000_00));
      write_byte(8'hD4, e);
      exp_q.push_back('{8'hD4, e0 + 127});
      wait_until(e0 + 49);
      write_byte(8'h5E, e);
      chk("coll_count3", 64'(cheio), 64'(1'b0));
      write_byte(8'h6F, e);
      chk("coll_count4", 64'(cheio), 64'(1'b1));
      exp_q.push_back('{8'h5E, e0 + 169});
      exp_q.push_back('{8'h6F, e0 + 211});
      wait_until(e0 + 84);
      write_byte(8'hEE, e);
      chk("full_pop_write_dropped", 64'({cheio, vazio}), 64'(2'b00));
      wait_idle("coll_idle", 600);

      repeat (5) @(posedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
